yzh_komut_sirayici: RTL and testbench

- Sequencer between the execute stage and the AI-accelerator convolution datapath (16-entry filter/data matrices with a per-cycle multiply-accumulate).
- Accepts decoded accelerator commands (load filter, load data, clear filter, clear data, conv run) over a valid/ready handshake.
- Drives the datapath's enable/clear/run strobes and holds conv-run until the accumulator has consumed every loaded pair. This removes the extra-cycle hazard when a load is immediately followed by conv.
- Returns the conv result to writeback over a valid/ready handshake.

---
 rtl/yzh_komut_sirayici.sv | 133 +++++++++++++
 tb/tb_yzh_komut_sirayici.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/yzh_komut_sirayici.sv
// yzh_komut_sirayici: sequences decoded accelerator commands into the convolution datapath
// Ports: clk_i/rst_i (sync active-high); komut_* valid/ready command input with rs1_i/rs2_i/rs2_en_i;
//   blok_aktif_o, filtre_*/veri_* load data+strobes, *_sil_o clear strobes, conv_yap_yaz_en_o run strobe;
//   conv_sonuc_i/conv_hazir_i datapath result; sonuc_o/sonuc_gecerli_o/sonuc_hazir_i writeback handshake;
//   hata_o overflow pulse.
// Macro YZH_TASMA_KORUMA_EN: drop loads that would overflow a matrix and pulse hata_o.
module yzh_komut_sirayici #(
  parameter int ELEMAN_SAYISI = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        komut_gecerli_i,
  output logic        komut_hazir_o,
  input  logic [2:0]  komut_tip_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        rs2_en_i,
  output logic        blok_aktif_o,
  output logic [31:0] filtre_rs1_o,
  output logic [31:0] veri_rs1_o,
  output logic [31:0] filtre_rs2_o,
  output logic [31:0] veri_rs2_o,
  output logic        filtre_rs1_en_o,
  output logic        filtre_rs2_en_o,
  output logic        veri_rs1_en_o,
  output logic        veri_rs2_en_o,
  output logic        filtre_sil_o,
  output logic        veri_sil_o,
  output logic        conv_yap_yaz_en_o,
  input  logic [31:0] conv_sonuc_i,
  input  logic        conv_hazir_i,
  output logic [31:0] sonuc_o,
  output logic        sonuc_gecerli_o,
  input  logic        sonuc_hazir_i,
  output logic        hata_o
);
  localparam int W = $clog2(ELEMAN_SAYISI) + 1;
  localparam logic [W:0] N1 = (W+1)'(ELEMAN_SAYISI);
  typedef enum logic [2:0] {BOS, BEKLE, CONV, AL, SONUC} durum_t;
  durum_t r_durum;
  logic [W-1:0] r_filtre_sayac, r_veri_sayac, r_tuketilen;
  logic [W-1:0] w_min, w_f_sonraki, w_v_sonraki;
  logic [W:0] w_f_top, w_v_top;
  logic w_kabul, w_tasma, w_yukle_f, w_yukle_v;
  assign komut_hazir_o = (r_durum == BOS) && blok_aktif_o;
  assign w_kabul = komut_gecerli_i && komut_hazir_o;
  // Counters advance on the edge where the datapath consumes the strobes.
  assign w_f_top = {1'b0, r_filtre_sayac} + (W+1)'(filtre_rs1_en_o) + (W+1)'(filtre_rs2_en_o);
  assign w_v_top = {1'b0, r_veri_sayac} + (W+1)'(veri_rs1_en_o) + (W+1)'(veri_rs2_en_o);
  assign w_f_sonraki = filtre_sil_o ? '0 : (w_f_top > N1 ? N1[W-1:0] : w_f_top[W-1:0]);
  assign w_v_sonraki = veri_sil_o ? '0 : (w_v_top > N1 ? N1[W-1:0] : w_v_top[W-1:0]);
  assign w_min = r_filtre_sayac < r_veri_sayac ? r_filtre_sayac : r_veri_sayac;
`ifdef YZH_TASMA_KORUMA_EN
  logic [W:0] w_ek;
  // Overflow is judged against the count including strobes still in flight.
  assign w_ek = rs2_en_i ? (W+1)'(2) : (W+1)'(1);
  assign w_tasma = (komut_tip_i == 3'd0 && ({1'b0, w_f_sonraki} + w_ek > N1)) ||
                   (komut_tip_i == 3'd1 && ({1'b0, w_v_sonraki} + w_ek > N1));
`else
  assign w_tasma = 1'b0;
  assign hata_o = 1'b0;
`endif
  assign w_yukle_f = w_kabul && komut_tip_i == 3'd0 && !w_tasma;
  assign w_yukle_v = w_kabul && komut_tip_i == 3'd1 && !w_tasma;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
      r_filtre_sayac <= '0;
      r_veri_sayac <= '0;
      r_tuketilen <= '0;
      blok_aktif_o <= 1'b0;
      filtre_rs1_o <= '0;
      filtre_rs2_o <= '0;
      veri_rs1_o <= '0;
      veri_rs2_o <= '0;
      filtre_rs1_en_o <= 1'b0;
      filtre_rs2_en_o <= 1'b0;
      veri_rs1_en_o <= 1'b0;
      veri_rs2_en_o <= 1'b0;
      filtre_sil_o <= 1'b0;
      veri_sil_o <= 1'b0;
      conv_yap_yaz_en_o <= 1'b0;
      sonuc_o <= '0;
      sonuc_gecerli_o <= 1'b0;
`ifdef YZH_TASMA_KORUMA_EN
      hata_o <= 1'b0;
`endif
    end else begin
      blok_aktif_o <= 1'b1;
      filtre_rs1_en_o <= w_yukle_f;
      filtre_rs2_en_o <= w_yukle_f && rs2_en_i;
      veri_rs1_en_o <= w_yukle_v;
      veri_rs2_en_o <= w_yukle_v && rs2_en_i;
      filtre_sil_o <= w_kabul && komut_tip_i == 3'd3;
      veri_sil_o <= w_kabul && komut_tip_i == 3'd4;
`ifdef YZH_TASMA_KORUMA_EN
      hata_o <= w_kabul && w_tasma;
`endif
      if (w_yukle_f) begin
        filtre_rs1_o <= rs1_i;
        filtre_rs2_o <= rs2_i;
      end
      if (w_yukle_v) begin
        veri_rs1_o <= rs1_i;
        veri_rs2_o <= rs2_i;
      end
      r_filtre_sayac <= w_f_sonraki;
      r_veri_sayac <= w_v_sonraki;
      // Mirrors the accumulator: one pair consumed per cycle while pairs remain.
      r_tuketilen <= (filtre_sil_o || veri_sil_o) ? '0 :
                     (r_tuketilen < w_min ? r_tuketilen + W'(1) : r_tuketilen);
      conv_yap_yaz_en_o <= 1'b0;
      case (r_durum)
        BOS: if (w_kabul && komut_tip_i == 3'd2) r_durum <= BEKLE;
        BEKLE: if (r_tuketilen == w_min) begin
          r_durum <= CONV;
          conv_yap_yaz_en_o <= 1'b1;
        end
        CONV: r_durum <= AL;
        AL: if (conv_hazir_i) begin
          sonuc_o <= conv_sonuc_i;
          sonuc_gecerli_o <= 1'b1;
          r_durum <= SONUC;
        end
        SONUC: if (sonuc_hazir_i) begin
          sonuc_gecerli_o <= 1'b0;
          r_durum <= BOS;
        end
        default: r_durum <= BOS;
      endcase
    end
  end
endmodule

// File: tb/tb_yzh_komut_sirayici.sv
// tb_yzh_komut_sirayici: directed bench with a simple datapath model
module tb_yzh_komut_sirayici;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic komut_gecerli_i = 1'b0;
  logic komut_hazir_o;
  logic [2:0] komut_tip_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic rs2_en_i = 1'b0;
  logic blok_aktif_o;
  logic [31:0] filtre_rs1_o, veri_rs1_o, filtre_rs2_o, veri_rs2_o;
  logic filtre_rs1_en_o, filtre_rs2_en_o, veri_rs1_en_o, veri_rs2_en_o;
  logic filtre_sil_o, veri_sil_o, conv_yap_yaz_en_o;
  logic [31:0] conv_sonuc_i;
  logic conv_hazir_i;
  logic [31:0] sonuc_o;
  logic sonuc_gecerli_o;
  logic sonuc_hazir_i = 1'b0;
  logic hata_o;
  logic [7:0] strb;
  int n_vec = 0, n_err = 0;

  yzh_komut_sirayici dut (
    .clk_i(clk_i), .rst_i(rst_i), .komut_gecerli_i(komut_gecerli_i), .komut_hazir_o(komut_hazir_o),
    .komut_tip_i(komut_tip_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs2_en_i(rs2_en_i),
    .blok_aktif_o(blok_aktif_o), .filtre_rs1_o(filtre_rs1_o), .veri_rs1_o(veri_rs1_o),
    .filtre_rs2_o(filtre_rs2_o), .veri_rs2_o(veri_rs2_o), .filtre_rs1_en_o(filtre_rs1_en_o),
    .filtre_rs2_en_o(filtre_rs2_en_o), .veri_rs1_en_o(veri_rs1_en_o), .veri_rs2_en_o(veri_rs2_en_o),
    .filtre_sil_o(filtre_sil_o), .veri_sil_o(veri_sil_o), .conv_yap_yaz_en_o(conv_yap_yaz_en_o),
    .conv_sonuc_i(conv_sonuc_i), .conv_hazir_i(conv_hazir_i), .sonuc_o(sonuc_o),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i), .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;
  assign strb = {filtre_rs1_en_o, filtre_rs2_en_o, veri_rs1_en_o, veri_rs2_en_o,
                 filtre_sil_o, veri_sil_o, conv_yap_yaz_en_o, hata_o};

  // Datapath model: indexed matrices that wrap, counts that saturate, result one cycle after run.
  logic [31:0] fm [16];
  logic [31:0] dm [16];
  int fc, vc;
  logic [3:0] fp, vp;
  function automatic logic [31:0] dot();
    logic [31:0] s = 0;
    for (int i = 0; i < ((fc < vc) ? fc : vc); i++) s += fm[i] * dm[i];
    return s;
  endfunction
  always @(posedge clk_i) begin
    if (rst_i) begin
      fc <= 0; vc <= 0; fp <= 0; vp <= 0; conv_hazir_i <= 1'b0; conv_sonuc_i <= '0;
    end else begin
      conv_hazir_i <= conv_yap_yaz_en_o;
      if (conv_yap_yaz_en_o) conv_sonuc_i <= dot();
      if (filtre_sil_o) begin
        fc <= 0; fp <= 0;
      end else if (filtre_rs1_en_o) begin
        fm[fp] <= filtre_rs1_o;
        if (filtre_rs2_en_o) fm[fp + 4'd1] <= filtre_rs2_o;
        fp <= fp + (filtre_rs2_en_o ? 4'd2 : 4'd1);
        fc <= (fc + (filtre_rs2_en_o ? 2 : 1) > 16) ? 16 : fc + (filtre_rs2_en_o ? 2 : 1);
      end
      if (veri_sil_o) begin
        vc <= 0; vp <= 0;
      end else if (veri_rs1_en_o) begin
        dm[vp] <= veri_rs1_o;
        if (veri_rs2_en_o) dm[vp + 4'd1] <= veri_rs2_o;
        vp <= vp + (veri_rs2_en_o ? 4'd2 : 4'd1);
        vc <= (vc + (veri_rs2_en_o ? 2 : 1) > 16) ? 16 : vc + (veri_rs2_en_o ? 2 : 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic komut(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b, input logic e);
    komut_gecerli_i = 1'b1; komut_tip_i = t; rs1_i = a; rs2_i = b; rs2_en_i = e;
    tick();
  endtask

  // Issues a conv, returns ticks until the run strobe, total ticks until valid (-1 on timeout),
  // the consumed count seen at the run strobe, and the result.
  task automatic do_conv(output int w, output int lat, output logic [4:0] tk, output logic [31:0] r);
    int k = 0;
    komut(3'd2, 0, 0, 1'b0);
    komut_gecerli_i = 1'b0;
    w = 0;
    while (!conv_yap_yaz_en_o && w < 60) begin tick(); w++; end
    tk = dut.r_tuketilen;
    while (!sonuc_gecerli_o && k < 20) begin tick(); k++; end
    lat = (w >= 60 || k >= 20) ? -1 : w + k;
    r = sonuc_o;
  endtask

  task automatic release_result();
    sonuc_hazir_i = 1'b1; tick(); sonuc_hazir_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    n_vec++; if ({blok_aktif_o, komut_hazir_o, sonuc_gecerli_o, strb} !== 11'd0) begin n_err++; $display("FAIL reset_outputs got %b exp 0", {blok_aktif_o, komut_hazir_o, sonuc_gecerli_o, strb}); end
    n_vec++; if (sonuc_o !== 32'd0) begin n_err++; $display("FAIL reset_sonuc got %0d exp 0", sonuc_o); end
    tick();
    n_vec++; if ({blok_aktif_o, komut_hazir_o} !== 2'b11) begin n_err++; $display("FAIL after_reset_aktif_hazir got %b exp 11", {blok_aktif_o, komut_hazir_o}); end
    komut(3'd0, 2, 3, 1'b1); komut_gecerli_i = 1'b0;
    n_vec++; if (strb !== 8'b1100_0000) begin n_err++; $display("FAIL ld_filtre_strobes got %b exp 11000000", strb); end
    n_vec++; if ({filtre_rs1_o, filtre_rs2_o} !== {32'd2, 32'd3}) begin n_err++; $display("FAIL ld_filtre_data got %0d,%0d exp 2,3", filtre_rs1_o, filtre_rs2_o); end
    tick();
    n_vec++; if (strb !== 8'd0) begin n_err++; $display("FAIL ld_filtre_one_cycle got %b exp 0", strb); end
    n_vec++; if (dut.r_filtre_sayac !== 5'd2) begin n_err++; $display("FAIL filtre_sayac got %0d exp 2", dut.r_filtre_sayac); end
  endtask

  task automatic test_conv_drain();
    int w, lat; logic [4:0] tk; logic [31:0] r;
    komut(3'd3, 0, 0, 1'b0);
    komut(3'd0, 2, 3, 1'b1);
    komut(3'd1, 4, 5, 1'b1);
    do_conv(w, lat, tk, r);
    n_vec++; if (w !== 3) begin n_err++; $display("FAIL drain_wait got %0d exp 3", w); end
    n_vec++; if (tk !== 5'd2) begin n_err++; $display("FAIL drain_tuketilen got %0d exp 2", tk); end
    n_vec++; if (r !== 32'd23) begin n_err++; $display("FAIL conv_23 got %0d exp 23", r); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({sonuc_o, sonuc_gecerli_o, komut_hazir_o} !== {32'd23, 1'b1, 1'b0}) begin n_err++; $display("FAIL hold_%0d got sonuc=%0d v=%b rdy=%b exp 23,1,0", i, sonuc_o, sonuc_gecerli_o, komut_hazir_o); end
    end
    release_result();
    n_vec++; if ({sonuc_gecerli_o, komut_hazir_o} !== 2'b01) begin n_err++; $display("FAIL release got v=%b rdy=%b exp 0,1", sonuc_gecerli_o, komut_hazir_o); end
  endtask

  task automatic test_sil_veri();
    int w, lat; logic [4:0] tk; logic [31:0] r;
    komut(3'd4, 0, 0, 1'b0); komut_gecerli_i = 1'b0;
    n_vec++; if (strb !== 8'b0000_0100) begin n_err++; $display("FAIL sil_veri_strobe got %b exp 00000100", strb); end
    tick();
    n_vec++; if ({dut.r_veri_sayac, dut.r_tuketilen} !== 10'd0) begin n_err++; $display("FAIL sil_counters got v=%0d t=%0d exp 0,0", dut.r_veri_sayac, dut.r_tuketilen); end
    do_conv(w, lat, tk, r);
    n_vec++; if (w !== 1 || lat !== 3) begin n_err++; $display("FAIL no_wait_timing got w=%0d lat=%0d exp 1,3", w, lat); end
    n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL conv_zero got %0d exp 0", r); end
    release_result();
  endtask

  task automatic test_full_overflow();
    int w, lat; logic [4:0] tk; logic [31:0] r;
    komut(3'd3, 0, 0, 1'b0);
    komut(3'd4, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) komut(3'd0, 2*i+1, 2*i+2, 1'b1);
    for (int i = 0; i < 8; i++) komut(3'd1, 1, 1, 1'b1);
    do_conv(w, lat, tk, r);
    n_vec++; if (lat < 0 || r !== 32'd136) begin n_err++; $display("FAIL conv_136 got %0d lat=%0d exp 136", r, lat); end
    n_vec++; if (dut.r_filtre_sayac !== 5'd16) begin n_err++; $display("FAIL full_count got %0d exp 16", dut.r_filtre_sayac); end
    release_result();
    komut(3'd0, 99, 0, 1'b0); komut_gecerli_i = 1'b0;
`ifdef YZH_TASMA_KORUMA_EN
    n_vec++; if ({filtre_rs1_en_o, hata_o} !== 2'b01) begin n_err++; $display("FAIL overflow got en=%b hata=%b exp 0,1", filtre_rs1_en_o, hata_o); end
`else
    n_vec++; if ({filtre_rs1_en_o, hata_o} !== 2'b10) begin n_err++; $display("FAIL overflow got en=%b hata=%b exp 1,0", filtre_rs1_en_o, hata_o); end
`endif
    tick();
    n_vec++; if ({hata_o, dut.r_filtre_sayac} !== {1'b0, 5'd16}) begin n_err++; $display("FAIL overflow_after got hata=%b cnt=%0d exp 0,16", hata_o, dut.r_filtre_sayac); end
  endtask

  task automatic test_reset_mid();
    int w, lat; logic [4:0] tk; logic [31:0] r;
    komut(3'd3, 0, 0, 1'b0);
    komut(3'd4, 0, 0, 1'b0);
    komut(3'd0, 1, 1, 1'b1);
    komut(3'd1, 1, 1, 1'b1);
    komut(3'd2, 0, 0, 1'b0); komut_gecerli_i = 1'b0;
    n_vec++; if (3'(dut.r_durum) !== 3'd1) begin n_err++; $display("FAIL in_bekle got %0d exp 1", dut.r_durum); end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_vec++; if ({3'(dut.r_durum), sonuc_gecerli_o, strb, dut.r_filtre_sayac, dut.r_veri_sayac, dut.r_tuketilen} !== 27'd0) begin n_err++; $display("FAIL rst_bekle got st=%0d v=%b s=%b f=%0d d=%0d t=%0d exp all 0", dut.r_durum, sonuc_gecerli_o, strb, dut.r_filtre_sayac, dut.r_veri_sayac, dut.r_tuketilen); end
    tick();
    komut(3'd0, 1, 1, 1'b1);
    komut(3'd1, 1, 1, 1'b1);
    do_conv(w, lat, tk, r);
    n_vec++; if (3'(dut.r_durum) !== 3'd4 || !sonuc_gecerli_o) begin n_err++; $display("FAIL in_sonuc got st=%0d v=%b exp 4,1", dut.r_durum, sonuc_gecerli_o); end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_vec++; if ({3'(dut.r_durum), sonuc_gecerli_o, strb, dut.r_filtre_sayac, dut.r_veri_sayac, dut.r_tuketilen} !== 27'd0) begin n_err++; $display("FAIL rst_sonuc got st=%0d v=%b s=%b f=%0d d=%0d t=%0d exp all 0", dut.r_durum, sonuc_gecerli_o, strb, dut.r_filtre_sayac, dut.r_veri_sayac, dut.r_tuketilen); end
    tick();
  endtask

  task automatic test_back_to_back();
    komut(3'd1, 7, 8, 1'b1);
    n_vec++; if ({strb, veri_rs1_o, veri_rs2_o, komut_hazir_o} !== {8'b0011_0000, 32'd7, 32'd8, 1'b1}) begin n_err++; $display("FAIL b2b_veri got s=%b d=%0d,%0d rdy=%b exp 00110000 7,8 1", strb, veri_rs1_o, veri_rs2_o, komut_hazir_o); end
    komut(3'd0, 9, 0, 1'b0);
    n_vec++; if ({strb, filtre_rs1_o} !== {8'b1000_0000, 32'd9}) begin n_err++; $display("FAIL b2b_filtre got s=%b d=%0d exp 10000000 9", strb, filtre_rs1_o); end
    komut(3'd6, 5, 5, 1'b1);
    n_vec++; if (strb !== 8'd0) begin n_err++; $display("FAIL b2b_nop got %b exp 0", strb); end
    komut(3'd1, 10, 0, 1'b0); komut_gecerli_i = 1'b0;
    n_vec++; if ({strb, veri_rs1_o} !== {8'b0010_0000, 32'd10}) begin n_err++; $display("FAIL b2b_veri2 got s=%b d=%0d exp 00100000 10", strb, veri_rs1_o); end
    tick();
    n_vec++; if ({dut.r_veri_sayac, dut.r_filtre_sayac} !== {5'd3, 5'd1}) begin n_err++; $display("FAIL b2b_counts got v=%0d f=%0d exp 3,1", dut.r_veri_sayac, dut.r_filtre_sayac); end
  endtask

  initial begin
    test_reset();
    test_conv_drain();
    test_sil_veri();
    test_full_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
